// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: each owner keeps the grant for up to weight[i] whole packets per turn.
// Latency: grant is registered one cycle after request in IDLE; every release costs exactly one IDLE cycle.
// Backpressure: out_ready only gates beat acceptance; the grant is locked to the owner between packet ends.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   arb_enable      permits new arbitration (and continuing a turn past a packet end)
//   request         per-requester request, held until its last beat is accepted
//   req_last        per-requester end-of-packet flag for the current beat
//   weight          packed packets-per-turn, requester i at [i*WEIGHT_W +: WEIGHT_W]; 0 acts as 1
//   out_ready       downstream accepts a beat
//   grant           registered one-hot grant or zero
//   grant_idx       binary index of the owner, valid while grant_valid is high
//   grant_valid     registered, high when grant is nonzero
module weighted_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WEIGHT_W = 4,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         arb_enable,
  input  logic [NUM_REQ-1:0]           request,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*WEIGHT_W-1:0]  weight,
  input  logic                         out_ready,
  output logic [NUM_REQ-1:0]           grant,
  output logic [IDX_W-1:0]             grant_idx,
  output logic                         grant_valid
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      ptr, ptr_nxt;
  logic [IDX_W-1:0]      idx_nxt;
  logic [WEIGHT_W-1:0]   credit, credit_nxt;
  logic [WEIGHT_W-1:0]   credit_dec;
  logic [NUM_REQ-1:0]    grant_nxt;
  logic                  valid_nxt;
  // Set for the cycle right after a packet end that did not release: the owner
  // must still be requesting then, otherwise its turn ends.
  logic                  boundary, boundary_nxt;

  logic [WEIGHT_W-1:0]   weight_arr [NUM_REQ];
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic [WEIGHT_W-1:0]   pick_weight;
  logic                  owner_req;
  logic                  owner_last;
  logic                  beat;
  logic                  pkt_end;
  logic [IDX_W-1:0]      ptr_after_owner;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_weight
    assign weight_arr[g] = weight[g*WEIGHT_W +: WEIGHT_W];
  end

  // First requester at or after ptr, wrapping at NUM_REQ (not at 2**IDX_W).
  always_comb begin
    int cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_found && request[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign pick_weight     = weight_arr[pick_idx];
  assign owner_req       = request[grant_idx];
  assign owner_last      = req_last[grant_idx];
  assign beat            = grant_valid & out_ready & owner_req;
  assign pkt_end         = beat & owner_last;
  assign credit_dec      = credit - WEIGHT_W'(1);
  assign ptr_after_owner = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      credit      <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      boundary    <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      credit      <= credit_nxt;
      grant       <= grant_nxt;
      grant_idx   <= idx_nxt;
      grant_valid <= valid_nxt;
      boundary    <= boundary_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    credit_nxt   = credit;
    grant_nxt    = grant;
    idx_nxt      = grant_idx;
    valid_nxt    = grant_valid;
    boundary_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (arb_enable && pick_found) begin
          state_nxt  = HOLD;
          idx_nxt    = pick_idx;
          grant_nxt  = NUM_REQ'(1) << pick_idx;
          valid_nxt  = 1'b1;
          credit_nxt = (pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;
        end
      end
      HOLD: begin
        if (pkt_end) begin
          credit_nxt = credit_dec;
          if (credit_dec == '0 || !arb_enable) begin
            state_nxt = IDLE;
            grant_nxt = '0;
            valid_nxt = 1'b0;
            ptr_nxt   = ptr_after_owner;
          end else begin
            boundary_nxt = 1'b1;
          end
        end else if (boundary && !owner_req) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          valid_nxt = 1'b0;
          ptr_nxt   = ptr_after_owner;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/weighted_rr_arbiter.md
WEIGHTED_RR_ARBITER -- requirements
Module: weighted_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, legal range 2..32.
REQ-002 SHALL have parameter WEIGHT_W, default 4: width of each per-requester packet-credit weight.
REQ-003 SHALL have parameter IDX_W, default $clog2(NUM_REQ): width of the grant index.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port arb_enable, input, 1: when high, new arbitration is permitted.
REQ-007 SHALL have port request, input, NUM_REQ: per-requester request; each requester holds it high until its last beat is accepted.
REQ-008 SHALL have port req_last, input, NUM_REQ: per-requester end-of-packet flag for the current beat.
REQ-009 SHALL have port weight, input, NUM_REQ*WEIGHT_W: packets per turn; requester i uses bits [i*WEIGHT_W +: WEIGHT_W].
REQ-010 SHALL have port out_ready, input, 1: downstream accepts a beat.
REQ-011 SHALL have port grant, output, NUM_REQ: registered one-hot grant, or all zero.
REQ-012 SHALL have port grant_idx, output, IDX_W: binary index of the owner, valid while grant_valid is high.
REQ-013 SHALL have port grant_valid, output, 1: registered; high when grant is nonzero.

Function
REQ-014 SHALL implement the two states IDLE and HOLD.
REQ-015 In IDLE, with arb_enable=1 and |request, SHALL select the first requesting index, searching upward from pointer ptr with wrap-around, and enter HOLD on the next edge with grant, grant_idx and grant_valid registered; latency is 1 cycle from request to grant.
REQ-016 On entry to HOLD, SHALL load the credit counter with weight[owner]; a weight of 0 SHALL load 1.
REQ-017 SHALL count a beat as transferred only in a cycle with grant_valid & out_ready & request[owner].
REQ-018 SHALL end a packet on a transferred beat with req_last[owner]=1, and SHALL decrement credit at each packet end.
REQ-019 SHALL lock the grant to the owner between packet ends, regardless of other requests, arb_enable, or owner request withdrawal.
REQ-020 At a packet end, if credit becomes 0, arb_enable=0, or request[owner] is not asserted in the following cycle, SHALL release: return to IDLE, clear grant and grant_valid, and set ptr = (owner+1) mod NUM_REQ.
REQ-021 At a packet end with none of the REQ-020 conditions, SHALL stay in HOLD with the same owner and no bubble.
REQ-022 Each release SHALL cost exactly one IDLE cycle before the next grant.
REQ-023 In IDLE with arb_enable=0, SHALL issue no grant, and SHALL leave ptr and credit unchanged.
REQ-024 Changes to weight SHALL take effect only at the next HOLD entry.
REQ-025 The ptr wrap from NUM_REQ-1 to 0 SHALL be correct for non-power-of-2 NUM_REQ.
REQ-026 grant SHALL always be one-hot or zero, and grant_idx SHALL match the grant bit.

Reset
REQ-027 On rst_n=0, SHALL immediately and asynchronously force grant=0, grant_valid=0, grant_idx=0, ptr=0, credit=0 and state=IDLE, including reset asserted mid-packet.
REQ-028 After rst_n deasserts, the first grant SHALL favour index 0 when several requesters are active.

Verification
REQ-029 With NUM_REQ=4, weights all 1, request=4'b1111, every beat last, out_ready=1 -> owners 0,1,2,3,0, each grant lasting 1 cycle followed by 1 IDLE cycle.
REQ-030 With weight0=3, weight1=1, request=4'b0011, single-beat packets -> owner 0 for 3 consecutive beats, then owner 1 for 1 beat, repeating.
REQ-031 Owner 2 sends a 4-beat packet while out_ready toggles 1,0,1,0,... and request3 is asserted -> grant stays 4'b0100 until the 4th accepted beat, then owner 3.
REQ-032 arb_enable drops mid-packet -> the packet completes, then the block releases, and grant stays 0 until arb_enable=1.
REQ-033 rst_n pulses low mid-HOLD -> grant and grant_valid go 0 in the same cycle without waiting for a clock edge, and the next grant follows the ptr=0 order.
REQ-034 With NUM_REQ=3 and only request2 active with weight 0 -> owner 2 is granted one packet per turn, and ptr wraps to 0.
